// File: rtl/output_send_sched.sv
// Layer-level scheduler for the output write-back path: issues one send command
// per output channel group and paces the groups on the send engine's busy handshake.
module output_send_sched #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned GRP_W       = 8
) (
  input  logic             CLK,
  input  logic             RSTL,
  input  logic             START,
  input  logic             POOL_MODE,
  input  logic [GRP_W-1:0] NUM_GROUPS,
  input  logic [15:0]      BASE_ADDR,
  input  logic [15:0]      ADDR_STRIDE,
  input  logic [5:0]       LAST_MASK,
  input  logic             module_busy,
  input  logic             OUTPUT_BUSY,
  output logic             OUTPUT_SEND,
  output logic             OUTPUT_SEND_POOL,
  output logic [GRP_W-1:0] COUNTER0,
  output logic [15:0]      WADDRX_I,
  output logic [5:0]       OUTPUT_EN_CTRL_I,
  output logic             SCHED_BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MOD,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_send,       w_send_nxt;
  logic             r_send_pool,  w_send_pool_nxt;
  logic [GRP_W-1:0] r_counter,    w_counter_nxt;
  logic [15:0]      r_waddr,      w_waddr_nxt;
  logic [5:0]       r_en,         w_en_nxt;
  logic             r_sched_busy, w_sched_busy_nxt;
  logic             r_done,       w_done_nxt;
  logic             r_err,        w_err_nxt;
  logic [TO_W-1:0]  r_to_cnt,     w_to_cnt_nxt;
  logic             r_pool,       w_pool_nxt;
  logic [GRP_W-1:0] r_num,        w_num_nxt;
  logic [15:0]      r_stride,     w_stride_nxt;
  logic [5:0]       r_last_mask,  w_last_mask_nxt;

  logic             w_last;
  logic [TO_W-1:0]  w_to_inc;
  logic             w_to_hit;

  assign w_last   = (r_counter == (r_num - GRP_W'(1)));
  assign w_to_inc = r_to_cnt + TO_W'(1);
  assign w_to_hit = (w_to_inc == TO_W'(ACK_TIMEOUT));

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (START) w_state_nxt = (NUM_GROUPS != '0) ? S_WAIT_MOD : S_FIN;
      S_WAIT_MOD:  if (!module_busy && !OUTPUT_BUSY) w_state_nxt = S_ISSUE;
      S_ISSUE:     w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:  begin
        if (OUTPUT_BUSY)   w_state_nxt = S_WAIT_DONE;
        else if (w_to_hit) w_state_nxt = S_FIN;
      end
      S_WAIT_DONE: if (!OUTPUT_BUSY) w_state_nxt = S_NEXT;
      S_NEXT:      w_state_nxt = w_last ? S_FIN : S_WAIT_MOD;
      S_FIN:       w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so their next values are keyed on the transition
  // being taken: the send pulse lands in the ISSUE cycle, DONE in the cycle after FIN.
  always_comb begin
    w_send_nxt       = 1'b0;
    w_send_pool_nxt  = 1'b0;
    w_done_nxt       = (r_state == S_FIN);
    w_sched_busy_nxt = (w_state_nxt != S_IDLE);
    w_counter_nxt    = r_counter;
    w_waddr_nxt      = r_waddr;
    w_en_nxt         = r_en;
    w_err_nxt        = r_err;
    w_to_cnt_nxt     = r_to_cnt;
    w_pool_nxt       = r_pool;
    w_num_nxt        = r_num;
    w_stride_nxt     = r_stride;
    w_last_mask_nxt  = r_last_mask;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_err_nxt = 1'b0;
          if (NUM_GROUPS != '0) begin
            w_pool_nxt      = POOL_MODE;
            w_num_nxt       = NUM_GROUPS;
            w_stride_nxt    = ADDR_STRIDE;
            w_last_mask_nxt = LAST_MASK;
            w_counter_nxt   = '0;
            w_waddr_nxt     = BASE_ADDR;
          end
        end
      end
      S_WAIT_MOD: begin
        if (w_state_nxt == S_ISSUE) begin
          w_send_nxt      = !r_pool;
          w_send_pool_nxt = r_pool;
          if (w_last) w_en_nxt = (r_last_mask == '0) ? 6'h3F : r_last_mask;
          else        w_en_nxt = 6'h3F;
        end
      end
      S_ISSUE: w_to_cnt_nxt = '0;
      S_WAIT_ACK: begin
        if (!OUTPUT_BUSY) begin
          w_to_cnt_nxt = w_to_inc;
          if (w_to_hit) w_err_nxt = 1'b1;
        end
      end
      S_NEXT: begin
        if (!w_last) begin
          w_counter_nxt = r_counter + GRP_W'(1);
          w_waddr_nxt   = r_waddr + r_stride;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      r_send       <= 1'b0;
      r_send_pool  <= 1'b0;
      r_counter    <= '0;
      r_waddr      <= '0;
      r_en         <= '0;
      r_sched_busy <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_to_cnt     <= '0;
      r_pool       <= 1'b0;
      r_num        <= '0;
      r_stride     <= '0;
      r_last_mask  <= '0;
    end else begin
      r_send       <= w_send_nxt;
      r_send_pool  <= w_send_pool_nxt;
      r_counter    <= w_counter_nxt;
      r_waddr      <= w_waddr_nxt;
      r_en         <= w_en_nxt;
      r_sched_busy <= w_sched_busy_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      r_pool       <= w_pool_nxt;
      r_num        <= w_num_nxt;
      r_stride     <= w_stride_nxt;
      r_last_mask  <= w_last_mask_nxt;
    end
  end

  assign OUTPUT_SEND      = r_send;
  assign OUTPUT_SEND_POOL = r_send_pool;
  assign COUNTER0         = r_counter;
  assign WADDRX_I         = r_waddr;
  assign OUTPUT_EN_CTRL_I = r_en;
  assign SCHED_BUSY       = r_sched_busy;
  assign DONE             = r_done;
  assign ERR              = r_err;

endmodule
